// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package ifu_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_e;

  // Architectural PC after reset unless overridden.
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // Instruction width is fixed by the ISA.
  localparam int IFU_INST_W = 32;

  // Which 32-bit lane of a bus word holds the instruction at an address.
  // Only address bit 2 matters, and only on a 64-bit bus.
  function automatic logic lane_idx(input logic addr_b2, input int bus_w);
    return (bus_w == 64) ? addr_b2 : 1'b0;
  endfunction

endpackage

// File: rtl/ifu_lane_sel.sv
// Extracts one 32-bit lane from a 32- or 64-bit bus word.
// Purely combinational so the data-side LSU can share it.
module ifu_lane_sel
  import ifu_pkg::*;
#(
  parameter int BUS_W  = 64,
  parameter int INST_W = IFU_INST_W
) (
  input  logic [BUS_W-1:0]  data_i,
  input  logic              lane_i,
  output logic [INST_W-1:0] inst_o
);

  generate
    if (BUS_W == 64) begin : g_bus64
      // Upper lane holds the word at address offset 4.
      assign inst_o = lane_i ? data_i[63:32] : data_i[31:0];
    end else begin : g_bus32
      logic unused_lane;
      assign unused_lane = lane_i;
      assign inst_o      = data_i[INST_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues aligned fetches over a
// valid/ready request channel, and hands inst/pc to decode through a
// registered valid/ready output. Redirects can land in any state; a fetch
// already accepted by memory is marked for drop and its response discarded.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              BUS_W    = 64,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0],
  parameter int              INST_W   = IFU_INST_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [XLEN-1:0]   req_addr,
  input  logic              resp_valid,
  input  logic [BUS_W-1:0]  resp_data,
  input  logic              resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   pc,
  output logic              fault
);

  // Low address bits dropped to align requests to the bus word.
  localparam int OFF = $clog2(BUS_W / 8);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              fault_q, fault_d;

  logic              req_hs;
  logic              out_hs;
  logic [INST_W-1:0] lane_inst;

  ifu_lane_sel #(
    .BUS_W  (BUS_W),
    .INST_W (INST_W)
  ) u_lane_sel (
    .data_i (resp_data),
    .lane_i (lane_idx(pc_q[2], BUS_W)),
    .inst_o (lane_inst)
  );

  // Outputs come straight from state so decode and memory see no
  // combinational path from their own inputs.
  assign req_valid = (state_q == REQ);
  assign req_addr  = {pc_q[XLEN-1:OFF], {OFF{1'b0}}};
  assign out_valid = (state_q == OUT);
  assign inst      = inst_q;
  assign fault     = fault_q;
  assign pc        = pc_q;

  assign req_hs = req_valid && req_ready;
  assign out_hs = out_valid && out_ready;

  // Next-state logic; a redirect overrides normal sequencing everywhere.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    fault_d = fault_q;

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        // Without a handshake the request is simply re-issued at the new
        // PC next cycle. With one, memory owes us a stale response.
        if (req_hs) begin
          state_d = WAIT;
          if (redirect_valid) drop_d = 1'b1;
        end
      end

      WAIT: begin
        if (resp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d  = resp_err ? '0 : lane_inst;
            fault_d = resp_err;
            state_d = OUT;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end

      OUT: begin
        // A redirect wins over acceptance: no pc+4, held inst is dropped.
        if (redirect_valid) begin
          state_d = REQ;
        end else if (out_hs) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and captured instruction registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

endmodule
